// File: rtl/ifu_prefetch.sv
// ifu_prefetch -- instruction-fetch front end for the MIPS core.
//
// Keeps the fetch PC, issues one outstanding word fetch at a time on a
// req/ack instruction-memory port and buffers the returned words, tagged
// with their fetch address, in a small circular prefetch queue. The queue
// head is offered to the datapath with a valid/ready handshake. When ctrl
// consumes a beq/j via nPC_sel, the queue is flushed and fetching restarts
// at the branch/jump target. A response that was already in flight when
// the redirect happened is discarded.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   im_req, im_addr     fetch request and word address (stable until im_ack)
//   im_ack, im_rdata    memory accept strobe and returned word
//   inst_valid, inst,   queue head (inst/inst_pc read 0 when empty)
//   inst_pc
//   inst_ready          datapath consumes the head this cycle
//   nPC_sel, zero       redirect control, sampled only when the head is consumed
//   perf_fetched,       (IFU_PERF_CNT_EN only) words pushed into the queue and
//   perf_flushed        words thrown away by redirects
//
// Configuration macro: IFU_PERF_CNT_EN adds the two performance counters.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic [1:0]  nPC_sel,
  input  logic        zero
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic          drop, drop_next;
  logic          im_req_next;
  logic [31:0]   im_addr_next;

  logic [31:0]   head_inst, head_pc, pc_plus4, beq_target, j_target, target;
  logic          pop, xfer, push, taken, issue_slot;

  assign head_inst  = q_inst[rd_ptr];
  assign head_pc    = q_pc[rd_ptr];
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head_inst : 32'h0;
  assign inst_pc    = inst_valid ? head_pc   : 32'h0;

  assign pop   = inst_valid & inst_ready;
  assign xfer  = im_req & im_ack;
  assign taken = pop & (((nPC_sel == 2'b01) & zero) | (nPC_sel == 2'b10));
  // A response landing on the redirect edge belongs to the old path.
  assign push  = xfer & ~drop & ~taken;

  assign pc_plus4   = head_pc + 32'd4;
  assign beq_target = pc_plus4 + {{14{head_inst[15]}}, head_inst[15:0], 2'b00};
  assign j_target   = {pc_plus4[31:28], head_inst[25:0], 2'b00};
  assign target     = nPC_sel[1] ? j_target : beq_target;

  // A new request may be launched only when none is pending after this edge.
  assign issue_slot = ~im_req | xfer;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the logic can leave one unassigned and infer a latch.
  always_comb begin
    count_next    = count;
    fetch_pc_next = fetch_pc;
    drop_next     = drop;
    im_req_next   = im_req;
    im_addr_next  = im_addr;

    if (taken) begin
      count_next    = '0;
      fetch_pc_next = target;
      // Still-pending request returns later on the old path: mark it stale.
      drop_next     = im_req & ~im_ack;
    end else begin
      count_next = count + CW'(push) - CW'(pop);
      if (push) fetch_pc_next = fetch_pc + 32'd4;
      if (xfer) drop_next = 1'b0;
    end

    // Reserve a queue slot for the word being requested, so a push into a
    // full queue can never happen.
    if (issue_slot) begin
      im_req_next  = (count_next < CW'(DEPTH));
      im_addr_next = fetch_pc_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_req   <= 1'b0;
      im_addr  <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      im_req   <= im_req_next;
      im_addr  <= im_addr_next;
      fetch_pc <= fetch_pc_next;
      drop     <= drop_next;
      count    <= count_next;
      if (taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        // Power-of-two depth: pointers wrap naturally.
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(push);
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read, and the
  // outputs are forced to 0 when the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= im_rdata;
      q_pc[wr_ptr]   <= im_addr;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_flushed <= 32'h0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      // Flushed = queued words behind the consumed head, plus the in-flight
      // response (discarded now or later via drop).
      if (taken) perf_flushed <= perf_flushed + 32'(count) - 32'd1 + 32'(im_req);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch -- self-checking bench for ifu_prefetch.
//
// The reference model is architectural: it tracks only the PC the datapath
// must see next. That PC starts at the reset PC. Each consumed instruction
// advances it by 4, or moves it to the beq/j target computed from the
// instruction word. Instruction memory is a pure function of the address.
// Directed scenarios pin the model with literal addresses. A randomized
// phase then exercises ack/ready/redirect interleavings.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [1:0]  nPC_sel = 2'b00;
  logic        zero = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .nPC_sel    (nPC_sel),
    .zero       (zero)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Program image: a j at 3000 (target field 0xC40), a beq at 3004 with
  // offset -2, and hashed filler words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h0800_0C40;
    if (a == 32'h0000_3004) return 32'h1000_FFFE;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign im_rdata = mem_word(im_addr);

  // Architectural next PC after executing word w at pc.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [1:0] sel,
                                          input logic z);
    logic [31:0] w, seq;
    int          off;
    w   = mem_word(pc);
    seq = pc + 32'd4;
    if (sel == 2'b10) return {seq[31:28], w[25:0], 2'b00};
    if (sel == 2'b01 && z) begin
      off = int'($signed(w[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs change only just after posedge, so values seen
  // at the negedge are exactly those the DUT uses at the next posedge.
  logic [31:0] exp_pc = RESET_PC;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc   = RESET_PC;
      prev_req = 1'b0;
    end else begin
      if (inst_valid) begin
        check("model_pc", inst_pc, exp_pc);
        check("model_inst", inst, mem_word(exp_pc));
        if (inst_ready) begin
          exp_pc = next_pc(exp_pc, nPC_sel, zero);
          n_pops++;
        end
      end else begin
        check("empty_inst", inst, 32'h0);
        check("empty_pc", inst_pc, 32'h0);
      end
      if (prev_req && !prev_ack) begin
        check("req_held", {31'h0, im_req}, 32'h1);
        check("addr_stable", im_addr, prev_addr);
      end
      if (im_req) check("addr_align", {30'h0, im_addr[1:0]}, 32'h0);
      prev_req  = im_req;
      prev_ack  = im_ack;
      prev_addr = im_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; im_ack = 1'b0; inst_ready = 1'b0; nPC_sel = 2'b00; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Advance until the head is the given PC; bounded.
  task automatic wait_head(input logic [31:0] pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (inst_valid && inst_pc == pc) found = 1'b1;
    end
    check("wait_head", {31'h0, found}, 32'h1);
  endtask

  initial begin
    // 1: reset state, then sequential stream with ack tied high.
    do_reset();
    check("rst_req", {31'h0, im_req}, 32'h0);
    check("rst_addr", im_addr, RESET_PC);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    im_ack = 1'b1; inst_ready = 1'b1;
    cyc();
    check("t1_req", {31'h0, im_req}, 32'h1);
    check("t1_addr0", im_addr, 32'h0000_3000);
    check("t1_notyet", {31'h0, inst_valid}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("t1_pc", inst_pc, 32'h0000_3000 + 32'(4 * k));
      check("t1_addr", im_addr, 32'h0000_3004 + 32'(4 * k));
    end

    // 2: consumer stalled -> exactly four words queued, fetch parks at 3010.
    do_reset();
    im_ack = 1'b1;
    repeat (8) cyc();
    check("t2_req_low", {31'h0, im_req}, 32'h0);
    check("t2_addr", im_addr, 32'h0000_3010);
    check("t2_head", inst_pc, 32'h0000_3000);
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t2_order", inst_pc, 32'h0000_3000 + 32'(4 * k));
      cyc();
    end
    inst_ready = 1'b0;

    // 3: beq at 3004, offset -2: taken -> 3000; not taken -> 3008, no flush.
    do_reset();
    im_ack = 1'b1; inst_ready = 1'b1;
    wait_head(32'h0000_3004);
    nPC_sel = 2'b01; zero = 1'b1;
    cyc();
    nPC_sel = 2'b00; zero = 1'b0;
    check("t3_flushed", {31'h0, inst_valid}, 32'h0);
    check("t3_refetch", im_addr, 32'h0000_3000);
    cyc();
    check("t3_taken_pc", inst_pc, 32'h0000_3000);
    wait_head(32'h0000_3004);
    nPC_sel = 2'b01; zero = 1'b0;
    cyc();
    nPC_sel = 2'b00;
    check("t3_nt_valid", {31'h0, inst_valid}, 32'h1);
    check("t3_nt_pc", inst_pc, 32'h0000_3008);
    cyc();
    check("t3_nt_next", inst_pc, 32'h0000_300C);

    // 4: j at 3000 -> 00003100, stale 3004 never delivered.
    do_reset();
    im_ack = 1'b1; inst_ready = 1'b1;
    wait_head(32'h0000_3000);
    nPC_sel = 2'b10;
    cyc();
    nPC_sel = 2'b00;
    check("t4_flushed", {31'h0, inst_valid}, 32'h0);
    check("t4_addr", im_addr, 32'h0000_3100);
    cyc();
    check("t4_pc", inst_pc, 32'h0000_3100);
    check("t4_inst", inst, mem_word(32'h0000_3100));
    cyc();
    check("t4_next", inst_pc, 32'h0000_3104);

    // 5: redirect while a slow fetch is outstanding.
    do_reset();
    im_ack = 1'b1;
    cyc();                        // request 3000 up
    cyc();                        // 3000 queued, request 3004 up
    check("t5_head", inst_pc, 32'h0000_3000);
    im_ack = 1'b0; inst_ready = 1'b1; nPC_sel = 2'b10;
    cyc();                        // j consumed, 3004 still pending
    nPC_sel = 2'b00; inst_ready = 1'b1;
    check("t5_flushed", {31'h0, inst_valid}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      check("t5_hold_req", {31'h0, im_req}, 32'h1);
      check("t5_hold_addr", im_addr, 32'h0000_3004);
      cyc();
    end
    im_ack = 1'b1;
    cyc();                        // stale response discarded
    check("t5_drop_valid", {31'h0, inst_valid}, 32'h0);
    check("t5_target_req", im_addr, 32'h0000_3100);
    cyc();
    check("t5_target_pc", inst_pc, 32'h0000_3100);

    // 6: reset pulse mid-request with a late ack.
    do_reset();
    cyc();
    cyc();
    check("t6_pending", {31'h0, im_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_req_drop", {31'h0, im_req}, 32'h0);
    check("t6_addr", im_addr, RESET_PC);
    im_ack = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_valid", {31'h0, inst_valid}, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("t6_perf_fetched", perf_fetched, 32'h0);
    check("t6_perf_flushed", perf_flushed, 32'h0);
`endif
    cyc();
    check("t6_refetch_req", {31'h0, im_req}, 32'h1);
    check("t6_refetch_addr", im_addr, RESET_PC);
    check("t6_no_stale", {31'h0, inst_valid}, 32'h0);
    cyc();
    check("t6_first", inst_pc, RESET_PC);

    // Randomized phase: three ack/ready mixes, model checked every cycle.
    do_reset();
    n_pops = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        int r;
        im_ack     = ($urandom_range(0, 99) < (ph == 0 ? 100 : (ph == 1 ? 60 : 25)));
        inst_ready = ($urandom_range(0, 99) < (ph == 1 ? 50 : 85));
        r = int'($urandom_range(0, 9));
        nPC_sel    = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        zero       = $urandom_range(0, 1) == 1;
        cyc();
      end
    end
    check("progress", {31'h0, n_pops > 300}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
